restart_ctrl: RTL

- System restart sequencer that sits directly downstream of the start-configuration stage; it consumes that stage's 9-bit start value (start_cfg).
- Gathers restart requests from three sources and drives a timed system reset pulse (sys_rst) to the CPU and peripherals, including the start stage.
- Sources: debounced push-button, watchdog timeout, software write.
- Records the restart cause and a snapshot of start_cfg, both readable over the THM bus after restart.
- The block itself is reset only by rst, never by sys_rst.

---
 rtl/restart_ctrl.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/restart_ctrl.sv
// ============================================================================
//  Module   : restart_ctrl
//  Purpose  : System restart sequencer. Merges button, watchdog and software
//             restart requests into a timed sys_rst pulse, and records the
//             restart cause plus a snapshot of start_cfg for bus readback.
//  Option   : RESTART_CTRL_COUNT_EN - adds a saturating 8-bit restart counter
//             readable in data_out[19:12], cleared by a write with data_in[2].
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module restart_ctrl #(
    parameter int RST_CYCLES      = 16,
    parameter int DEBOUNCE_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        ack,
    input  logic        rst_btn_n,
    input  logic        wd_trig,
    input  logic [8:0]  start_cfg,
    output logic        sys_rst,
    output logic        busy
);

    localparam int                 c_CNT_W    = $clog2(RST_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(RST_CYCLES - 1);
    localparam int                 c_DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ASSERT  = 2'd1;
    localparam logic [1:0] c_ST_RELEASE = 2'd2;

    localparam logic [2:0] c_CAUSE_NONE = 3'd0;
    localparam logic [2:0] c_CAUSE_BTN  = 3'd1;
    localparam logic [2:0] c_CAUSE_WD   = 3'd2;
    localparam logic [2:0] c_CAUSE_SW   = 3'd3;
    localparam logic [2:0] c_CAUSE_POR  = 3'd4;

    logic               r_btn_s1;
    logic               r_btn_s2;
    logic               r_btn_db;
    logic [c_DB_W-1:0]  r_db_cnt;
    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2:0]         r_cause;
    logic [8:0]         r_snap;

    logic               w_rd;
    logic               w_wr;
    logic               w_sw_trig;
    logic               w_clr;
    logic               w_btn_trig;
    logic               w_any_trig;
    logic [2:0]         w_trig_code;
    logic [7:0]         w_count_rd;

    // Bus decode: zero-wait-state acknowledge, requests taken from write data
    assign ack       = stb;
    assign w_rd      = stb & ~we;
    assign w_wr      = stb & we;
    assign w_sw_trig = w_wr & data_in[0];
    assign w_clr     = w_wr & data_in[1];

    // Button is asynchronous: two-flop synchronizer, idle level is released (1)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_s1 <= 1'b1;
            r_btn_s2 <= 1'b1;
        end else begin
            r_btn_s1 <= rst_btn_n;
            r_btn_s2 <= r_btn_s1;
        end
    end

    // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_btn_db <= 1'b1;
            r_db_cnt <= '0;
        end else if (r_btn_s2 == r_btn_db) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
            r_btn_db <= r_btn_s2;
            r_db_cnt <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + 1'b1;
        end
    end

    // Fires only on the cycle the debounced level goes released -> pressed
    assign w_btn_trig = r_btn_db & ~r_btn_s2 & (r_db_cnt == c_DB_LAST);
    assign w_any_trig = w_btn_trig | wd_trig | w_sw_trig;

    // Cause encoding with button > watchdog > software priority
    always_comb begin
        w_trig_code = c_CAUSE_SW;
        if (wd_trig)    w_trig_code = c_CAUSE_WD;
        if (w_btn_trig) w_trig_code = c_CAUSE_BTN;
    end

    // Restart sequencer: reset lands in ASSERT so power-on produces a full pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_ASSERT;
            r_cnt   <= '0;
            sys_rst <= 1'b1;
            busy    <= 1'b1;
            r_cause <= c_CAUSE_POR;
            r_snap  <= 9'd0;
        end else begin
            // A clear is overridden below when the same cycle starts a restart
            if (w_clr) r_cause <= c_CAUSE_NONE;
            case (r_state)
                c_ST_IDLE: begin
                    sys_rst <= 1'b0;
                    busy    <= 1'b0;
                    if (w_any_trig) begin
                        r_state <= c_ST_ASSERT;
                        r_cnt   <= '0;
                        sys_rst <= 1'b1;
                        busy    <= 1'b1;
                        r_cause <= w_trig_code;
                        r_snap  <= start_cfg;
                    end
                end
                c_ST_ASSERT: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_state <= c_ST_RELEASE;
                        sys_rst <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_RELEASE: begin
                    r_state <= c_ST_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    sys_rst <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef RESTART_CTRL_COUNT_EN
    logic       w_accept;
    logic       w_cnt_clr;
    logic [7:0] r_restart_cnt;
    logic       w_unused_data;

    assign w_accept      = (r_state == c_ST_IDLE) & w_any_trig;
    assign w_cnt_clr     = w_wr & data_in[2];
    assign w_unused_data = ^data_in[31:3];

    // Saturating count of accepted restarts; an accepted trigger beats a clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_restart_cnt <= 8'd0;
        end else if (w_accept) begin
            if (w_cnt_clr)                  r_restart_cnt <= 8'd1;
            else if (r_restart_cnt != 8'hFF) r_restart_cnt <= r_restart_cnt + 8'd1;
        end else if (w_cnt_clr) begin
            r_restart_cnt <= 8'd0;
        end
    end

    assign w_count_rd = r_restart_cnt;
`else
    logic w_unused_data;

    assign w_unused_data = ^data_in[31:2];
    assign w_count_rd    = 8'd0;
`endif

    assign data_out = w_rd ? {12'd0, w_count_rd, r_cause, r_snap} : 32'd0;

endmodule

`default_nettype wire
